// File: rtl/hdmi_line_fetcher_if.sv
// Burst-read port between the line fetcher (master) and the frame-buffer
// memory controller (slave).
interface hdmi_line_fetcher_if #(
  parameter int AW = 24
) ();
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [13:0]   mem_rd_len;
  logic          mem_rd_ack;
  logic          mem_rd_valid;
  logic [23:0]   mem_rd_data;

  modport master (
    output mem_rd_req, mem_rd_addr, mem_rd_len,
    input  mem_rd_ack, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, mem_rd_len,
    output mem_rd_ack, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/hdmi_line_fetcher.sv
// Two-bank line prefetcher feeding the HDMI TX pixel request/response port
// with a fixed one-cycle response latency.
module hdmi_line_fetcher #(
  parameter int H_WIDTH     = 640,
  parameter int V_HEIGHT    = 480,
  parameter int AW          = 24,
  parameter int LINE_STRIDE = 640
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic [AW-1:0]              fb_base,
  input  logic                       req_en,
  input  logic                       req_sof,
  input  logic                       req_eof,
  input  logic                       req_sol,
  input  logic                       req_eol,
  output logic [7:0]                 resp_red,
  output logic [7:0]                 resp_green,
  output logic [7:0]                 resp_blue,
  hdmi_line_fetcher_if.master        mem,
  output logic                       underflow,
  output logic [15:0]                frame_cnt
);
  localparam int BW = (H_WIDTH > 1) ? $clog2(H_WIDTH) : 1;
  localparam int LW = (V_HEIGHT > 1) ? $clog2(V_HEIGHT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(H_WIDTH - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(V_HEIGHT - 1);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DATA = 2'd2
  } fetch_state_t;

  fetch_state_t  state_r;
  logic [23:0]   lb_r [2][H_WIDTH];
  logic [1:0]    full_r;
  logic [1:0]    full_nxt_s;
  logic          fetch_bank_r;
  logic          read_bank_r;
  logic [LW-1:0] line_idx_r;
  logic [BW-1:0] beat_cnt_r;
  logic [BW-1:0] pix_idx_r;
  logic [BW-1:0] rd_idx_s;
  logic [AW-1:0] addr_r;
  logic          req_r;
  logic [13:0]   len_r;
  logic [23:0]   resp_r;
  logic          underflow_r;
  logic [15:0]   frame_cnt_r;
  logic          beat_s;
  logic          done_s;
  logic          eol_s;
  logic          flush_s;
  logic          ready_s;
  logic          unused_sof_s;

  // Frame start needs no action: the line index free-runs across frames.
  assign unused_sof_s = req_sof;

  // Per-cycle events and the next value of the bank full flags.
  always_comb begin
    beat_s     = (state_r == F_DATA) && mem.mem_rd_valid;
    done_s     = beat_s && (beat_cnt_r == LAST_BEAT);
    eol_s      = req_en && req_eol;
    flush_s    = !enable && (state_r == F_IDLE);
    ready_s    = enable && full_r[read_bank_r];
    rd_idx_s   = req_sol ? {BW{1'b0}} : pix_idx_r;
    full_nxt_s = full_r;
    if (flush_s) begin
      full_nxt_s = 2'b00;
    end else begin
      // Consumer release and producer completion may land in the same cycle.
      full_nxt_s[read_bank_r]  = eol_s  ? 1'b0 : full_nxt_s[read_bank_r];
      full_nxt_s[fetch_bank_r] = done_s ? 1'b1 : full_nxt_s[fetch_bank_r];
    end
  end

  // Fetch FSM: burst request, beat counting, bank and line bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= F_IDLE;
      req_r        <= 1'b0;
      addr_r       <= {AW{1'b0}};
      len_r        <= 14'd0;
      beat_cnt_r   <= {BW{1'b0}};
      line_idx_r   <= {LW{1'b0}};
      fetch_bank_r <= 1'b0;
      read_bank_r  <= 1'b0;
      full_r       <= 2'b00;
    end else begin
      len_r  <= 14'(H_WIDTH);
      full_r <= full_nxt_s;
      if (flush_s) begin
        read_bank_r <= 1'b0;
      end else if (eol_s) begin
        read_bank_r <= !read_bank_r;
      end
      case (state_r)
        F_IDLE: begin
          if (flush_s) begin
            line_idx_r   <= {LW{1'b0}};
            fetch_bank_r <= 1'b0;
          end else if (!full_r[fetch_bank_r]) begin
            state_r <= F_REQ;
            req_r   <= 1'b1;
            // Line 0 re-anchors on fb_base; later lines accumulate the stride.
            addr_r  <= (line_idx_r == {LW{1'b0}}) ? fb_base
                                                   : addr_r + AW'(LINE_STRIDE);
          end
        end
        F_REQ: begin
          if (mem.mem_rd_ack) begin
            req_r      <= 1'b0;
            beat_cnt_r <= {BW{1'b0}};
            state_r    <= F_DATA;
          end
        end
        F_DATA: begin
          if (done_s) begin
            fetch_bank_r <= !fetch_bank_r;
            line_idx_r   <= (line_idx_r == LAST_LINE) ? {LW{1'b0}}
                                                      : line_idx_r + LW'(1);
            state_r      <= F_IDLE;
          end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r <= F_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer write port; contents only matter behind a set full flag.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      lb_r[fetch_bank_r][beat_cnt_r] <= mem.mem_rd_data;
    end
  end

  // Pixel response path, underflow flag and frame counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_r      <= 24'd0;
      underflow_r <= 1'b0;
      frame_cnt_r <= 16'd0;
      pix_idx_r   <= {BW{1'b0}};
    end else if (req_en) begin
      resp_r    <= ready_s ? lb_r[read_bank_r][rd_idx_s] : 24'd0;
      pix_idx_r <= req_eol ? {BW{1'b0}} : rd_idx_s + BW'(1);
      if (!ready_s) begin
        underflow_r <= 1'b1;
      end
      if (req_eof) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  assign resp_red        = resp_r[23:16];
  assign resp_green      = resp_r[15:8];
  assign resp_blue       = resp_r[7:0];
  assign underflow       = underflow_r;
  assign frame_cnt       = frame_cnt_r;
  assign mem.mem_rd_req  = req_r;
  assign mem.mem_rd_addr = addr_r;
  assign mem.mem_rd_len  = len_r;
endmodule

// File: tb/tb_hdmi_line_fetcher.sv
// Directed bench for hdmi_line_fetcher with a small 8x4 frame and a
// configurable burst-memory responder.
module tb_hdmi_line_fetcher;
  localparam int H      = 8;
  localparam int V      = 4;
  localparam int AW     = 24;
  localparam int STRIDE = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] fb_base = 24'd0;
  logic        req_en = 1'b0, req_sof = 1'b0, req_eof = 1'b0;
  logic        req_sol = 1'b0, req_eol = 1'b0;
  logic [7:0]  resp_red, resp_green, resp_blue;
  logic        underflow;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_dly  = 0;
  int lat      = 0;
  int cur_beat = -1;
  bit req_dropped = 1'b0;
  bit req_after_ack = 1'b0;
  logic [23:0] addr_q [$];
  logic [13:0] len_q  [$];

  always #5 clk = ~clk;

  hdmi_line_fetcher_if #(.AW(AW)) mif ();

  hdmi_line_fetcher #(
    .H_WIDTH(H), .V_HEIGHT(V), .AW(AW), .LINE_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .fb_base(fb_base),
    .req_en(req_en), .req_sof(req_sof), .req_eof(req_eof),
    .req_sol(req_sol), .req_eol(req_eol),
    .resp_red(resp_red), .resp_green(resp_green), .resp_blue(resp_blue),
    .mem(mif), .underflow(underflow), .frame_cnt(frame_cnt)
  );

  // Frame-buffer content: pixel word stored at address a.
  function automatic logic [23:0] pix(input logic [23:0] a);
    logic [7:0] lo, hi;
    lo = a[7:0];
    hi = a[15:8] - 8'h10;
    return {lo, lo + 8'd1, lo + 8'd2 + hi};
  endfunction

  // Memory responder: acks after ack_dly cycles, beats after lat cycles.
  initial begin
    logic [23:0] a;
    mif.mem_rd_ack = 1'b0;
    mif.mem_rd_valid = 1'b0;
    mif.mem_rd_data = 24'd0;
    forever begin
      @(negedge clk);
      if (rstn && mif.mem_rd_req) begin
        for (int k = 0; k < ack_dly; k++) begin
          @(negedge clk);
          if (!mif.mem_rd_req) req_dropped = 1'b1;
        end
        a = mif.mem_rd_addr;
        addr_q.push_back(a);
        len_q.push_back(mif.mem_rd_len);
        mif.mem_rd_ack = 1'b1;
        @(negedge clk);
        mif.mem_rd_ack = 1'b0;
        if (mif.mem_rd_req) req_after_ack = 1'b1;
        for (int k = 0; k < lat; k++) @(negedge clk);
        for (int i = 0; i < H; i++) begin
          cur_beat = i;
          mif.mem_rd_valid = 1'b1;
          mif.mem_rd_data = pix(a + 24'(i));
          @(negedge clk);
        end
        mif.mem_rd_valid = 1'b0;
        cur_beat = -1;
      end
    end
  end

  task automatic req_cycle(input logic en, input logic sol, input logic eol,
                           input logic sof, input logic eof);
    @(negedge clk);
    req_en = en; req_sol = sol; req_eol = eol; req_sof = sof; req_eof = eof;
  endtask

  task automatic wait_bursts(input int n);
    for (int t = 0; t < 300 && addr_q.size() < n; t++) @(negedge clk);
  endtask

  task automatic do_reset();
    addr_q.delete();
    len_q.delete();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if ({resp_red, resp_green, resp_blue} !== 24'd0) begin n_fail++; $display("FAIL reset_resp: got %h want 000000", {resp_red, resp_green, resp_blue}); end
    n_checks++; if (mif.mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mif.mem_rd_req); end
    n_checks++; if (mif.mem_rd_addr !== 24'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mif.mem_rd_addr); end
    n_checks++; if (mif.mem_rd_len !== 14'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", mif.mem_rd_len); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_burst_issue();
    fb_base = 24'h001000; enable = 1'b1; ack_dly = 3; lat = 0;
    rstn = 1'b1;
    wait_bursts(2);
    n_checks++; if (addr_q.size() < 2) begin n_fail++; $display("FAIL burst_count: got %0d want 2", addr_q.size()); end
    n_checks++; if (addr_q[0] !== 24'h001000) begin n_fail++; $display("FAIL burst0_addr: got %h want 001000", addr_q[0]); end
    n_checks++; if (len_q[0] !== 14'd8) begin n_fail++; $display("FAIL burst0_len: got %0d want 8", len_q[0]); end
    n_checks++; if (addr_q[1] !== 24'h001008) begin n_fail++; $display("FAIL burst1_addr: got %h want 001008", addr_q[1]); end
    n_checks++; if (len_q[1] !== 14'd8) begin n_fail++; $display("FAIL burst1_len: got %0d want 8", len_q[1]); end
    n_checks++; if (req_dropped !== 1'b0) begin n_fail++; $display("FAIL req_held: req dropped before ack"); end
    n_checks++; if (req_after_ack !== 1'b0) begin n_fail++; $display("FAIL req_release: req still high after ack"); end
    repeat (30) @(negedge clk);
    n_checks++; if (addr_q.size() != 2) begin n_fail++; $display("FAIL prefetch_depth: got %0d bursts want 2", addr_q.size()); end
  endtask

  task automatic test_line_read();
    for (int i = 0; i <= H; i++) begin
      req_cycle(i < H, i == 0, i == H - 1, 1'b0, 1'b0);
      if (i > 0) begin
        n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(24'h001000 + 24'(i - 1))) begin n_fail++; $display("FAIL line_pix%0d: got %h want %h", i - 1, {resp_red, resp_green, resp_blue}, pix(24'h001000 + 24'(i - 1))); end
      end
    end
    req_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(24'h001007)) begin n_fail++; $display("FAIL resp_hold: got %h want %h", {resp_red, resp_green, resp_blue}, pix(24'h001007)); end
    wait_bursts(3);
    n_checks++; if (addr_q[2] !== 24'h001010) begin n_fail++; $display("FAIL burst2_addr: got %h want 001010", addr_q[2]); end
  endtask

  task automatic test_frames();
    logic [23:0] exp_seq [10];
    logic [23:0] base;
    exp_seq = '{24'h001000, 24'h001008, 24'h001010, 24'h001018, 24'h001000,
                24'h001008, 24'h001010, 24'h001018, 24'h002000, 24'h002008};
    fb_base = 24'h001000; ack_dly = 0; lat = 3; enable = 1'b1;
    do_reset();
    wait_bursts(2);
    repeat (20) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < V; l++) begin
        if (f == 1 && l == 1) fb_base = 24'h002000;
        base = 24'h001000 + 24'(STRIDE * l);
        for (int i = 0; i <= H; i++) begin
          req_cycle(i < H, i == 0, i == H - 1, i == 0 && l == 0, i == H - 1 && l == V - 1);
          if (i > 0) begin
            n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(base + 24'(i - 1))) begin n_fail++; $display("FAIL frame%0d_line%0d_pix%0d: got %h want %h", f, l, i - 1, {resp_red, resp_green, resp_blue}, pix(base + 24'(i - 1))); end
          end
        end
        repeat (25) @(negedge clk);
      end
    end
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL frame_cnt: got %0d want 2", frame_cnt); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL frames_underflow: got %b want 0", underflow); end
    n_checks++; if (addr_q.size() != 10) begin n_fail++; $display("FAIL frames_bursts: got %0d want 10", addr_q.size()); end
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (addr_q[k] !== exp_seq[k]) begin n_fail++; $display("FAIL frames_addr%0d: got %h want %h", k, addr_q[k], exp_seq[k]); end
    end
  endtask

  task automatic test_underflow();
    fb_base = 24'h001000; ack_dly = 10; lat = 0; enable = 1'b1;
    do_reset();
    req_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    req_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({resp_red, resp_green, resp_blue} !== 24'd0) begin n_fail++; $display("FAIL early_resp: got %h want 000000", {resp_red, resp_green, resp_blue}); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL early_underflow: got %b want 1", underflow); end
    req_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_bursts(2);
    repeat (20) @(negedge clk);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", underflow); end
    req_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    req_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(24'h001000)) begin n_fail++; $display("FAIL late_resp: got %h want %h", {resp_red, resp_green, resp_blue}, pix(24'h001000)); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_held: got %b want 1", underflow); end
  endtask

  task automatic test_disable();
    bit found;
    fb_base = 24'h003000; ack_dly = 0; lat = 0; enable = 1'b1;
    do_reset();
    wait_bursts(2);
    repeat (15) @(negedge clk);
    for (int i = 0; i <= H; i++) begin
      req_cycle(i < H, i == 0, i == H - 1, 1'b0, 1'b0);
      if (i > 0) begin
        n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(24'h003000 + 24'(i - 1))) begin n_fail++; $display("FAIL dis_pre_pix%0d: got %h want %h", i - 1, {resp_red, resp_green, resp_blue}, pix(24'h003000 + 24'(i - 1))); end
      end
    end
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge clk);
      if (mif.mem_rd_valid && cur_beat == 3) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL dis_beat3: beat 3 not seen, got 0 want 1"); end
    #1 enable = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (addr_q.size() != 3) begin n_fail++; $display("FAIL dis_no_burst: got %0d bursts want 3", addr_q.size()); end
    n_checks++; if (mif.mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL dis_req: got %b want 0", mif.mem_rd_req); end
    req_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    req_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({resp_red, resp_green, resp_blue} !== 24'd0) begin n_fail++; $display("FAIL dis_resp: got %h want 000000", {resp_red, resp_green, resp_blue}); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL dis_underflow: got %b want 1", underflow); end
    fb_base = 24'h004000;
    enable = 1'b1;
    wait_bursts(5);
    n_checks++; if (addr_q[3] !== 24'h004000) begin n_fail++; $display("FAIL reen_addr0: got %h want 004000", addr_q[3]); end
    n_checks++; if (addr_q[4] !== 24'h004008) begin n_fail++; $display("FAIL reen_addr1: got %h want 004008", addr_q[4]); end
    repeat (15) @(negedge clk);
    for (int i = 0; i <= H; i++) begin
      req_cycle(i < H, i == 0, i == H - 1, 1'b0, 1'b0);
      if (i > 0) begin
        n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(24'h004000 + 24'(i - 1))) begin n_fail++; $display("FAIL reen_pix%0d: got %h want %h", i - 1, {resp_red, resp_green, resp_blue}, pix(24'h004000 + 24'(i - 1))); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit found;
    fb_base = 24'h005000;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge clk);
      if (mif.mem_rd_valid && cur_beat == 4) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_beat4: beat 4 not seen, got 0 want 1"); end
    #1 rstn = 1'b0;
    #1;
    n_checks++; if ({resp_red, resp_green, resp_blue} !== 24'd0) begin n_fail++; $display("FAIL mid_resp: got %h want 000000", {resp_red, resp_green, resp_blue}); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL mid_underflow: got %b want 0", underflow); end
    n_checks++; if (mif.mem_rd_addr !== 24'd0) begin n_fail++; $display("FAIL mid_addr: got %h want 0", mif.mem_rd_addr); end
    n_checks++; if (mif.mem_rd_len !== 14'd0) begin n_fail++; $display("FAIL mid_len: got %0d want 0", mif.mem_rd_len); end
    n_checks++; if (mif.mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", mif.mem_rd_req); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_bursts(7);
    n_checks++; if (addr_q[6] !== 24'h005000) begin n_fail++; $display("FAIL mid_refetch_addr: got %h want 005000", addr_q[6]); end
    wait_bursts(8);
    repeat (15) @(negedge clk);
    for (int i = 0; i <= H; i++) begin
      req_cycle(i < H, i == 0, i == H - 1, 1'b0, 1'b0);
      if (i > 0) begin
        n_checks++; if ({resp_red, resp_green, resp_blue} !== pix(24'h005000 + 24'(i - 1))) begin n_fail++; $display("FAIL mid_pix%0d: got %h want %h", i - 1, {resp_red, resp_green, resp_blue}, pix(24'h005000 + 24'(i - 1))); end
      end
    end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL mid_underflow_after: got %b want 0", underflow); end
  endtask

  initial begin
    test_reset();
    test_burst_issue();
    test_line_read();
    test_frames();
    test_underflow();
    test_disable();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
